// File: rtl/if_fetch_queue_pkg.sv
// Shared types for the RV32I instruction-fetch front end: queue entry layout,
// fetch FSM state encoding and a word-alignment helper.
package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FQ_IDLE,
    FQ_WAIT,
    FQ_SQUASH
  } fetch_state_t;

  // Instructions are word aligned; redirect targets drop their low two bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// In-order FIFO of fetch_entry_t used to hold returned instructions with their PCs.
// Flush has priority over push/pop; the head entry is presented combinationally.
module fetch_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define which entries are live,
  // so clearing the array would cost reset routing without changing behaviour.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, one outstanding imem request,
// response squash on redirect and an in-order queue to ID. Optional macro FETCHQ_BYPASS_EN.
module if_fetch_queue
  import rv32i_types::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          kept_resp;
  logic          bypass_hit;
  logic          push;
  logic          pop;
  logic          issue;
  logic [CW:0]   reserve;

  assign kept_resp = (state == FQ_WAIT) && imem_resp && !redirect_valid;

`ifdef FETCHQ_BYPASS_EN
  assign bypass_hit = kept_resp && (count == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  assign out_valid = ((count != '0) || bypass_hit) && !redirect_valid;
  assign pop       = (count != '0) && out_valid && out_ready;
  assign push      = kept_resp && !(bypass_hit && out_ready);

  // An outstanding kept request owns a slot, whether its data lands this cycle or later.
  assign reserve = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(state == FQ_WAIT);

  assign issue = !rst && !redirect_valid
              && ((state == FQ_IDLE) || imem_resp)
              && (reserve < (CW+1)'(DEPTH));

  assign imem_addr  = fetch_pc;
  assign imem_rmask = issue ? 4'hF : 4'h0;
  assign push_entry = '{pc: req_pc, inst: imem_rdata};

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    out_pc   = '0;
    out_inst = '0;
    if (count != '0) begin
      out_pc   = head.pc;
      out_inst = head.inst;
    end else if (bypass_hit) begin
      out_pc   = req_pc;
      out_inst = imem_rdata;
    end
  end

  // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FQ_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= align_word(redirect_pc);
      if (imem_resp) begin
        state <= FQ_IDLE;
      end else if (state == FQ_WAIT) begin
        state <= FQ_SQUASH;
      end
    end else if (issue) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + 32'd4;
      state    <= FQ_WAIT;
    end else if (imem_resp) begin
      // A response with no back-to-back issue retires the request; stray ones in IDLE stay IDLE.
      state <= FQ_IDLE;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .din  (push_entry),
    .head (head),
    .count(count)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized scoreboard bench for if_fetch_queue; the reference model tracks fetch epochs
// and expected queue contents. Honours FETCHQ_BYPASS_EN for same-cycle visibility.
module tb_if_fetch_queue;
  import rv32i_types::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata = '0;
  logic        imem_resp = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  always #5 clk = ~clk;

  if_fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rmask    (imem_rmask),
    .imem_rdata    (imem_rdata),
    .imem_resp     (imem_resp),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          ready;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          accepted = 0;
  bit          have_out = 0;
  logic [31:0] out_addr = '0;
  int          out_epoch = 0;
  int          resp_due = 0;
  logic [31:0] exp_fetch = RESET_PC;
  int          lat_lo = 2;
  int          lat_hi = 2;
  int          ready_mode = 1;

  // Memory image: a fixed scramble of the address, so every word is distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h00130013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One cycle of stimulus plus the imem responder and the reference-model update.
  task automatic step(input bit r, input bit stray, input bit redir,
                      input logic [31:0] rpc, output bit issued);
    bit resp;
    int rdy;
    @(negedge clk);
    cyc++;
    rst            = r;
    resp           = !r && (stray || (have_out && cyc >= resp_due));
    imem_resp      = resp;
    imem_rdata     = (have_out && resp) ? mem_word(out_addr) : $urandom;
    redirect_valid = !r && redir;
    redirect_pc    = redir ? rpc : $urandom;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
    #1;
    issued = 0;
    if (r) begin
      check("rmask_in_reset", 32'(imem_rmask), 32'h0);
      exp_q.delete();
      have_out  = 0;
      exp_fetch = RESET_PC;
      epoch++;
      return;
    end
    issued = (imem_rmask != 4'h0);
    if (issued) begin
      check("rmask_value", 32'(imem_rmask), 32'hF);
      check("imem_addr", imem_addr, exp_fetch);
      check("issue_while_outstanding", 32'(have_out && !resp), 32'h0);
      check("issue_on_redirect", 32'(redirect_valid), 32'h0);
    end
    if (have_out && resp) begin
      if (!redirect_valid && out_epoch == epoch) begin
`ifdef FETCHQ_BYPASS_EN
        rdy = (exp_q.size() == 0) ? cyc : cyc + 1;
`else
        rdy = cyc + 1;
`endif
        exp_q.push_back('{pc: out_addr, inst: mem_word(out_addr), ready: rdy});
      end
      have_out = 0;
    end
    if (redirect_valid) begin
      epoch++;
      exp_q.delete();
      exp_fetch = {rpc[31:2], 2'b00};
    end
    if (issued) begin
      have_out  = 1;
      out_addr  = imem_addr;
      out_epoch = epoch;
      resp_due  = cyc + $urandom_range(lat_lo, lat_hi);
      exp_fetch = exp_fetch + 32'd4;
    end
  endtask

  // Monitor: compares the ID-side interface against the scoreboard every cycle.
  initial begin
    exp_t e;
    bit   exp_vis;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check("out_valid_reset", 32'(out_valid), 32'h0);
        check("out_pc_reset", out_pc, 32'h0);
        check("out_inst_reset", out_inst, 32'h0);
      end else begin
        exp_vis = !redirect_valid && (exp_q.size() > 0) && (exp_q[0].ready <= cyc);
        check("out_valid", 32'(out_valid), 32'(exp_vis));
        if (out_valid && out_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_inst", out_inst, e.inst);
          accepted++;
        end
      end
    end
  end

  initial begin
    bit          iss;
    int          n;
    int          i;
    logic [31:0] rnd;

    repeat (3) step(1, 0, 0, '0, iss);

    // Sequential fetch, two-cycle responses, ID always ready.
    ready_mode = 1; lat_lo = 2; lat_hi = 2;
    repeat (30) step(0, 0, 0, '0, iss);
    check("seq_progress", 32'(accepted >= 10), 32'h1);

    // Backpressure: queue fills with exactly DEPTH requests, then one slot frees one request.
    ready_mode = 0; lat_lo = 1; lat_hi = 1;
    step(0, 0, 1, 32'h1eceb400, iss);
    n = 0;
    repeat (20) begin step(0, 0, 0, '0, iss); n += int'(iss); end
    check("fill_requests", 32'(n), 32'(DEPTH));
    ready_mode = 1;
    step(0, 0, 0, '0, iss);
    n = int'(iss);
    ready_mode = 0;
    repeat (10) begin step(0, 0, 0, '0, iss); n += int'(iss); end
    check("refill_requests", 32'(n), 32'h1);

    // Redirect while a three-cycle request is outstanding.
    ready_mode = 1; lat_lo = 3; lat_hi = 3;
    repeat (10) step(0, 0, 0, '0, iss);
    i = 0;
    iss = 0;
    while (!iss && i < 20) begin step(0, 0, 0, '0, iss); i++; end
    check("squash_setup", 32'(iss), 32'h1);
    step(0, 0, 1, 32'h1eceb100, iss);
    n = accepted;
    repeat (20) step(0, 0, 0, '0, iss);
    check("squash_progress", 32'(accepted > n), 32'h1);

    // Redirect in the very cycle the response arrives, with an unaligned target.
    lat_lo = 2; lat_hi = 2;
    i = 0;
    while (!(have_out && resp_due == cyc + 1) && i < 20) begin step(0, 0, 0, '0, iss); i++; end
    check("coincide_setup", 32'(have_out && resp_due == cyc + 1), 32'h1);
    step(0, 0, 1, 32'h1eceb203, iss);
    step(0, 0, 0, '0, iss);
    check("coincide_issue", 32'(iss), 32'h1);
    check("coincide_addr", imem_addr, 32'h1eceb200);
    repeat (10) step(0, 0, 0, '0, iss);

    // Reset mid-request, then a stray response right after release.
    lat_lo = 3; lat_hi = 3;
    i = 0;
    while (!have_out && i < 20) begin step(0, 0, 0, '0, iss); i++; end
    check("reset_setup", 32'(have_out), 32'h1);
    repeat (2) step(1, 0, 0, '0, iss);
    step(0, 1, 0, '0, iss);
    check("reset_first_issue", 32'(iss), 32'h1);
    check("reset_first_addr", imem_addr, RESET_PC);
    repeat (10) step(0, 0, 0, '0, iss);

    // Randomized traffic: variable latency, random ready, occasional redirects.
    ready_mode = 2; lat_lo = 1; lat_hi = 4;
    n = accepted;
    repeat (1500) begin
      rnd = $urandom;
      step(0, 0, ($urandom_range(0, 99) < 4), {16'h1ece, rnd[15:0]}, iss);
    end
    check("random_progress", 32'(accepted - n > 200), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
